// File: rtl/cmac_seq_pkg.sv
// Shared types and constants for the CMAC dot-product sequencer.
package cmac_seq_pkg;

    // Latency of the current CMAC from operand issue to a valid out_mul/out_add.
    localparam int CMAC_LAT = 2;

    // Component width of the packed complex word used by the PE datapath.
    localparam int CPLX_DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Packed complex word: real part occupies the upper half.
    typedef struct packed {
        logic [CPLX_DW-1:0] re;
        logic [CPLX_DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/cmac_dot_seq_lat_pipe.sv
// Valid-bit delay line that mirrors the CMAC pipeline depth, so the
// sequencer knows in which cycle each issued product reaches the add stage.
module lat_pipe #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [LAT-1:0] stage_reg;
    logic [LAT-1:0] stage_next;

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_next[gi] = din;
            end else begin : g_body
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    // Shift one position per cycle; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign dout = stage_reg[LAT-1];

endmodule

// File: rtl/cmac_dot_seq.sv
// Sequencer that streams complex operand pairs into a shared CMAC and folds
// each product into a running accumulator through the CMAC's own add stage.
module cmac_dot_seq
    import cmac_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_W      = 8,
    parameter int LAT        = CMAC_LAT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic [4:0]              cfg_shift,
    input  logic [2*DATA_WIDTH-1:0] cfg_bias,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] in_a,
    input  logic [2*DATA_WIDTH-1:0] in_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*DATA_WIDTH-1:0] res_data,
    output logic                    busy,
    output logic                    cm_mac,
    output logic [4:0]              cm_shift,
    output logic [2*DATA_WIDTH-1:0] cm_opa,
    output logic [2*DATA_WIDTH-1:0] cm_opb,
    output logic [2*DATA_WIDTH-1:0] cm_opc,
    output logic [2*DATA_WIDTH-1:0] cm_opd,
    input  logic [2*DATA_WIDTH-1:0] cm_out_add
);

    localparam int CW = 2 * DATA_WIDTH;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    seq_state_t       state_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] issued_reg;
    logic [LEN_W-1:0] retired_reg;
    logic [4:0]       shift_reg;
    logic [CW-1:0]    acc_reg;

    logic in_fire;
    logic retire;

    assign cfg_ready = (state_reg == IDLE);
    assign in_ready  = (state_reg == ISSUE);
    assign busy      = (state_reg != IDLE);
    assign res_valid = (state_reg == DONE);
    assign res_data  = acc_reg;
    assign in_fire   = in_valid && in_ready;

    // Operand ports follow the input bus only while issuing; idle cycles
    // present zeros so the CMAC sees no spurious multiplies.
    assign cm_mac   = in_fire;
    assign cm_opa   = in_ready ? in_a : '0;
    assign cm_opb   = in_ready ? in_b : '0;
    assign cm_shift = shift_reg;

    // The accumulator always rides on opc: on a retire cycle the CMAC adds the
    // arriving product to it, otherwise opc + 0 just passes it through.
    assign cm_opc = acc_reg;
    assign cm_opd = '0;

    lat_pipe #(
        .LAT (LAT)
    ) u_lat_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (in_fire),
        .dout  (retire)
    );

    // Job FSM: latch the job, count issues and retires, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            len_reg     <= '0;
            issued_reg  <= '0;
            retired_reg <= '0;
            shift_reg   <= '0;
            acc_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cfg_valid) begin
                        len_reg     <= cfg_len;
                        shift_reg   <= cfg_shift;
                        acc_reg     <= cfg_bias;
                        issued_reg  <= '0;
                        retired_reg <= '0;
                        state_reg   <= (cfg_len != '0) ? ISSUE : DONE;
                    end
                end
                ISSUE: begin
                    if (retire) begin
                        acc_reg     <= cm_out_add;
                        retired_reg <= retired_reg + LEN_ONE;
                    end
                    if (in_fire) begin
                        issued_reg <= issued_reg + LEN_ONE;
                        if (issued_reg == len_reg - LEN_ONE) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (retire) begin
                        acc_reg     <= cm_out_add;
                        retired_reg <= retired_reg + LEN_ONE;
                        if (retired_reg + LEN_ONE == len_reg) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmac_dot_seq.sv
// Directed bench for cmac_dot_seq with a behavioural two-cycle CMAC.
`timescale 1ns/1ps
module tb_cmac_dot_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_len;
    logic [4:0]  cfg_shift;
    logic [31:0] cfg_bias;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;
    logic        cm_mac;
    logic [4:0]  cm_shift;
    logic [31:0] cm_opa, cm_opb, cm_opc, cm_opd;
    logic [31:0] cm_out_add;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] job_a [4];
    logic [31:0] job_b [4];

    always #5 clk = ~clk;

    cmac_dot_seq #(
        .DATA_WIDTH (16),
        .LEN_W      (8),
        .LAT        (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_len    (cfg_len),
        .cfg_shift  (cfg_shift),
        .cfg_bias   (cfg_bias),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .cm_mac     (cm_mac),
        .cm_shift   (cm_shift),
        .cm_opa     (cm_opa),
        .cm_opb     (cm_opb),
        .cm_opc     (cm_opc),
        .cm_opd     (cm_opd),
        .cm_out_add (cm_out_add)
    );

    // Behavioural CMAC: out_mul = opa + opb after two cycles; the add stage
    // uses the current opc/opd, selected by mac delayed two cycles.
    logic [31:0] mul_d1 = '0;
    logic [31:0] mul_d2 = '0;
    logic        macd   = 1'b0;
    logic        macdd  = 1'b0;

    always @(posedge clk) begin
        mul_d1 <= cm_opa + cm_opb;
        mul_d2 <= mul_d1;
        macd   <= cm_mac;
        macdd  <= macd;
    end

    assign cm_out_add = macdd ? (mul_d2 + cm_opc) : (cm_opc + cm_opd);

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, act);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".cfg_ready"}, 64'(cfg_ready), 64'd1);
        check({tag, ".in_ready"},  64'(in_ready),  64'd0);
        check({tag, ".res_valid"}, 64'(res_valid), 64'd0);
        check({tag, ".busy"},      64'(busy),      64'd0);
        check({tag, ".cm_mac"},    64'(cm_mac),    64'd0);
        check({tag, ".res_data"},  64'(res_data),  64'd0);
        check({tag, ".cm_shift"},  64'(cm_shift),  64'd0);
        check({tag, ".cm_ops"},    {cm_opa | cm_opb, cm_opc | cm_opd}, 64'd0);
    endtask

    // One full job: cfg, operands (with optional idle gaps), result, release.
    task automatic run_job(input string tag, input int len, input logic [4:0] sh,
                           input logic [31:0] bias, input int gap,
                           input logic [31:0] exp_data);
        int k;
        cfg_valid = 1'b1;
        cfg_len   = 8'(len);
        cfg_shift = sh;
        cfg_bias  = bias;
        @(negedge clk);
        check({tag, ".cfg_ready"}, 64'(cfg_ready), 64'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            in_a     = job_a[i];
            in_b     = job_b[i];
            @(negedge clk);
            check($sformatf("%s.mac%0d", tag, i), 64'(cm_mac), 64'd1);
            check($sformatf("%s.opa%0d", tag, i), 64'(cm_opa), 64'(job_a[i]));
            check($sformatf("%s.shift%0d", tag, i), 64'(cm_shift), 64'(sh));
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i < len - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check($sformatf("%s.gapmac%0d_%0d", tag, i, g), 64'(cm_mac), 64'd0);
                    check($sformatf("%s.gaprdy%0d_%0d", tag, i, g), 64'(in_ready), 64'd1);
                    @(posedge clk); #1;
                end
            end
        end
        k = 1;
        @(negedge clk);
        while (!res_valid && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check({tag, ".latency"}, 64'(k), (len == 0) ? 64'd1 : 64'd3);
        check({tag, ".res_data"}, 64'(res_data), 64'(exp_data));
        if (len == 0) check({tag, ".mac_zero"}, 64'(cm_mac), 64'd0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_len   = '0;
        cfg_shift = '0;
        cfg_bias  = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            job_a[i] = '0;
            job_b[i] = '0;
        end

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 0x100 + 0x11 + 0x22 + 0x33 = 0x166
        job_a[0] = 32'h1;  job_a[1] = 32'h2;  job_a[2] = 32'h3;
        job_b[0] = 32'h10; job_b[1] = 32'h20; job_b[2] = 32'h30;
        run_job("b2b", 3, 5'd3, 32'h100, 0, 32'h166);
        run_job("gap", 3, 5'd9, 32'h100, 2, 32'h166);

        // Zero-length job returns the bias the cycle after cfg.
        run_job("len0", 0, 5'd1, 32'hABCD, 0, 32'hABCD);

        // Hold the result: 0 + (2 + 3) = 5; a pending cfg must wait for IDLE.
        job_a[0] = 32'h2; job_b[0] = 32'h3;
        cfg_valid = 1'b1; cfg_len = 8'd1; cfg_shift = 5'd0; cfg_bias = 32'h0;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        in_valid = 1'b1; in_a = job_a[0]; in_b = job_b[0];
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cfg_valid = 1'b1; cfg_len = 8'd0; cfg_bias = 32'h77;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("hold.res_valid%0d", c), 64'(res_valid), 64'd1);
            check($sformatf("hold.res_data%0d", c), 64'(res_data), 64'd5);
            check($sformatf("hold.rdys%0d", c), {62'd0, cfg_ready, in_ready}, 64'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("bubble.cfg_ready", 64'(cfg_ready), 64'd1);
        check("bubble.res_valid", 64'(res_valid), 64'd0);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        check("bubble.res_valid2", 64'(res_valid), 64'd1);
        check("bubble.res_data", 64'(res_data), 64'h77);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;

        // Reset after 2 of 4 pairs, then a fresh job: 0 + (1 + 1) = 2.
        cfg_valid = 1'b1; cfg_len = 8'd4; cfg_shift = 5'd7; cfg_bias = 32'h55;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = 32'h4; in_b = 32'h5;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("midjob.busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        job_a[0] = 32'h1; job_b[0] = 32'h1;
        run_job("post_rst", 1, 5'd0, 32'h0, 0, 32'h2);

        // 0xFFFFFFFF + (1 + 0) wraps to 0.
        job_a[0] = 32'h1; job_b[0] = 32'h0;
        run_job("wrap", 1, 5'd0, 32'hFFFF_FFFF, 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
